// File: rtl/ts_rx_analyzer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ts_rx_analyzer                                                    |
// | Per-lane receive TS analyzer: classifies TS1/TS2, counts consecutive       |
// | identical TSs and raises a sticky "received enough" flag for core_fsm.     |
// | Optional gap watchdog is built when TSA_GAP_WDOG_EN is defined.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ts_rx_analyzer #(
    parameter int CNT_W   = 5,
    parameter int GAP_MAX = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [127:0]       ts_i,
    input  logic               ts_i_vld,
    input  logic               clr,
    input  logic [1:0]         expect_type,
    input  logic [CNT_W-1:0]   cnt_tgt,
    output logic               rcv_enough,
    output logic [1:0]         ts_type,
    output logic [7:0]         ts_link,
    output logic [7:0]         ts_lane,
    output logic [7:0]         ts_rate,
    output logic [7:0]         ts_ctrl,
    output logic [CNT_W-1:0]   consec_cnt,
    output logic               bad_ts,
    output logic               gap_timeout
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_ACCUM   = 2'd1;
    localparam logic [1:0]       c_DONE    = 2'd2;
    localparam logic [7:0]       c_COM     = 8'hBC;
    localparam logic [7:0]       c_TS1_ID  = 8'h4A;
    localparam logic [7:0]       c_TS2_ID  = 8'h45;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, w_tgt;
    logic             r_rcv, w_rcv_nxt;
    logic             r_bad, w_bad_nxt;
    logic             w_latch;
    logic [1:0]       r_type;
    logic [7:0]       r_link, r_lane, r_rate, r_ctrl;
    logic             w_all_ts1, w_all_ts2;
    logic [1:0]       w_type;
    logic             w_match, w_same, w_gap_fire;
    logic             w_unused_cfg;

    // Symbol 3 (N_FTS) deliberately takes no part in classification or matching.
    assign w_unused_cfg = ^{ts_i[31:24], (GAP_MAX > 0)};

    always_comb begin
        w_all_ts1 = 1'b1;
        w_all_ts2 = 1'b1;
        for (int k = 6; k < 16; k++) begin
            w_all_ts1 = w_all_ts1 & (ts_i[8*k +: 8] == c_TS1_ID);
            w_all_ts2 = w_all_ts2 & (ts_i[8*k +: 8] == c_TS2_ID);
        end
    end

    assign w_type = (ts_i[7:0] != c_COM) ? 2'b00 :
                    w_all_ts1            ? 2'b01 :
                    w_all_ts2            ? 2'b10 : 2'b00;

    assign w_match = (expect_type != 2'b11) &&
                     ((expect_type == 2'b00) || (expect_type == w_type));

    assign w_same = (w_type == r_type) && (ts_i[15:8] == r_link) &&
                    (ts_i[23:16] == r_lane) && (ts_i[39:32] == r_rate) &&
                    (ts_i[47:40] == r_ctrl);

    assign w_tgt     = (cnt_tgt == '0) ? c_CNT_ONE : cnt_tgt;
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rcv_nxt   = r_rcv;
        w_bad_nxt   = 1'b0;
        w_latch     = 1'b0;
        if (clr) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
            w_rcv_nxt   = 1'b0;
        end else if (ts_i_vld) begin
            if (w_type == 2'b00 || !w_match) begin
                // Rejected TS breaks the run but never revokes a reached target.
                w_bad_nxt   = (w_type == 2'b00);
                w_cnt_nxt   = '0;
                w_state_nxt = r_rcv ? c_DONE : c_IDLE;
            end else begin
                w_latch   = (r_cnt == '0) || !w_same;
                w_cnt_nxt = w_latch ? c_CNT_ONE : w_cnt_inc;
                if (w_cnt_nxt >= w_tgt) begin
                    w_rcv_nxt   = 1'b1;
                    w_state_nxt = c_DONE;
                end else begin
                    w_state_nxt = r_rcv ? c_DONE : c_ACCUM;
                end
            end
        end else if (w_gap_fire) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_rcv   <= 1'b0;
            r_bad   <= 1'b0;
            r_type  <= 2'b00;
            r_link  <= 8'h00;
            r_lane  <= 8'h00;
            r_rate  <= 8'h00;
            r_ctrl  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcv   <= w_rcv_nxt;
            r_bad   <= w_bad_nxt;
            if (w_latch) begin
                r_type <= w_type;
                r_link <= ts_i[15:8];
                r_lane <= ts_i[23:16];
                r_rate <= ts_i[39:32];
                r_ctrl <= ts_i[47:40];
            end
        end
    end

`ifdef TSA_GAP_WDOG_EN
    localparam int                 c_GAP_W    = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_MAX - 1);

    logic [c_GAP_W-1:0] r_gap;
    logic               r_gto;

    // A TS arriving on the expiry cycle wins; the watchdog stays silent.
    assign w_gap_fire = !clr && !ts_i_vld && (r_state == c_ACCUM) && (r_gap == c_GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || ts_i_vld || w_gap_fire) begin
            r_gap <= '0;
        end else if (r_state == c_ACCUM) begin
            r_gap <= r_gap + c_GAP_ONE;
        end
        r_gto <= rst ? 1'b0 : w_gap_fire;
    end

    assign gap_timeout = r_gto;
`else
    assign w_gap_fire  = 1'b0;
    assign gap_timeout = 1'b0;
`endif

    assign rcv_enough = r_rcv;
    assign ts_type    = r_type;
    assign ts_link    = r_link;
    assign ts_lane    = r_lane;
    assign ts_rate    = r_rate;
    assign ts_ctrl    = r_ctrl;
    assign consec_cnt = r_cnt;
    assign bad_ts     = r_bad;

endmodule
`default_nettype wire
